// File: rtl/pc_fetch_ctrl.sv
// Program counter owner and instruction fetch handshake.
// Optional misaligned-fetch trap: define FETCH_ALIGN_CHECK_EN.
module pc_fetch_ctrl #(
  parameter int unsigned        DATA_W   = 32,
  parameter logic [DATA_W-1:0]  RESET_PC = 32'hBFC0_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pcnext,
  input  logic              stall,
  output logic [DATA_W-1:0] pc,
  output logic              pcvalid,
  output logic [DATA_W-1:0] instr,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              fetch_err
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] HOLD = 3'd3;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic [2:0] ERR  = 3'd4;
`endif

  logic [2:0]        state;
  logic [2:0]        state_nx;
  logic [2:0]        go_req;
  logic [DATA_W-1:0] buffer;
  logic              rsp;

  // a response counts only in WAIT or with its own grant in REQ
  assign rsp = imem_rvalid &
               ((state == WAIT) |
                ((state == REQ) & imem_gnt));

  assign pcvalid = (rsp & ~stall) |
                   ((state == HOLD) & ~stall);

  assign imem_req = (state == REQ);

  always_comb begin
    instr = '0;
    if (state == HOLD)
      instr = buffer;
    else if (rsp)
      instr = imem_rdata;
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic [1:0] lo;
  // low bits of the pc that REQ will present
  assign lo = (state == IDLE) ? pc[1:0]
                              : pcnext[1:0];
  assign go_req    = (|lo) ? ERR : REQ;
  assign imem_addr = pc;
  assign fetch_err = (state == ERR);
`else
  assign go_req    = REQ;
  assign imem_addr = pc & ~DATA_W'(3);
  assign fetch_err = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: state_nx = go_req;
      REQ: begin
        if (imem_gnt) begin
          if (!imem_rvalid)
            state_nx = WAIT;
          else if (stall)
            state_nx = HOLD;
          else
            state_nx = go_req;
        end
      end
      WAIT: begin
        if (imem_rvalid)
          state_nx = stall ? HOLD : go_req;
      end
      HOLD: begin
        if (!stall)
          state_nx = go_req;
      end
      default: state_nx = state;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      buffer <= '0;
    end else begin
      state <= state_nx;
      if (pcvalid)
        pc <= pcnext;
      if (rsp & stall)
        buffer <= imem_rdata;
    end
  end

endmodule
